// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and a selectable FWFT read mode.
module sync_fifo_flagged #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AE_THRESH  = 1,
    parameter bit          FWFT       = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cs,
    input  logic                          wr_ena,
    input  logic                          rd_ena,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flagged: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= FIFO_DEPTH))) begin : g_bad_thresh
        $error("sync_fifo_flagged: thresholds must satisfy AE_THRESH < AF_THRESH <= FIFO_DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance uses the registered flags, so a full FIFO rejects a write
    // even when a read frees a slot on the same edge (and vice versa).
    assign wr_acc = cs & wr_ena & ~full;
    assign rd_acc = cs & rd_ena & ~empty;

    assign full         = (count == CW'(FIFO_DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc)      count <= count + 1'b1;
            else if (rd_acc && !wr_acc) count <= count - 1'b1;
            overflow  <= cs & wr_ena & full;
            underflow <= cs & rd_ena & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr] <= data_in;
    end

    if (FWFT) begin : g_fwft
        assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (rst)         data_out <= '0;
            else if (rd_acc) data_out <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Self-checking bench for sync_fifo_flagged: table-driven vectors with a data
// scoreboard on the standard-mode instance, plus hand sequences for reset and FWFT.
module tb_sync_fifo_flagged;

    logic        clk = 1'b0;
    logic        rst, cs, wr_ena, rd_ena;
    logic [31:0] data_in;

    logic [31:0] d0_data_out, d1_data_out;
    logic        d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf;
    logic        d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf;
    logic [3:0]  d0_count, d1_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        c;
        logic        w;
        logic        r;
        logic [31:0] d;
        int          cnt;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t        vec[$];
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    sync_fifo_flagged #(
        .DATA_WIDTH(32), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1'b0)
    ) u_std (
        .clk(clk), .rst(rst), .cs(cs), .wr_ena(wr_ena), .rd_ena(rd_ena),
        .data_in(data_in), .data_out(d0_data_out), .full(d0_full), .empty(d0_empty),
        .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
        .overflow(d0_ovf), .underflow(d0_udf)
    );

    sync_fifo_flagged #(
        .DATA_WIDTH(32), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1'b1)
    ) u_fwft (
        .clk(clk), .rst(rst), .cs(cs), .wr_ena(wr_ena), .rd_ena(rd_ena),
        .data_in(data_in), .data_out(d1_data_out), .full(d1_full), .empty(d1_empty),
        .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
        .overflow(d1_ovf), .underflow(d1_udf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic c, input logic w, input logic r, input logic [31:0] d,
                       input int cnt, input logic o, input logic u);
        vec.push_back('{c, w, r, d, cnt, o, u});
    endtask

    task automatic chk_std(input string tag, input int cnt, input logic o, input logic u,
                           input logic [31:0] dout);
        chk({tag, " count"}, 64'(d0_count), 64'(cnt));
        chk({tag, " full"}, 64'(d0_full), 64'(cnt == 8));
        chk({tag, " empty"}, 64'(d0_empty), 64'(cnt == 0));
        chk({tag, " almost_full"}, 64'(d0_af), 64'(cnt >= 6));
        chk({tag, " almost_empty"}, 64'(d0_ae), 64'(cnt <= 1));
        chk({tag, " overflow"}, 64'(d0_ovf), 64'(o));
        chk({tag, " underflow"}, 64'(d0_udf), 64'(u));
        chk({tag, " data_out"}, 64'(d0_data_out), 64'(dout));
    endtask

    initial begin
        logic [31:0] exp_dout;
        int          mcnt;
        logic        wacc, racc;

        // Fill, overflow, drain, underflow, then empty/full same-cycle corners
        for (int k = 1; k <= 8; k++) add(1, 1, 0, 32'h11 * k, k, 0, 0);
        add(1, 1, 0, 32'hDEADBEEF, 8, 1, 0);
        add(1, 0, 0, 32'h0, 8, 0, 0);
        add(1, 1, 1, 32'hDEADBEEF, 7, 1, 0);
        for (int k = 6; k >= 0; k--) add(1, 0, 1, 32'h0, k, 0, 0);
        add(1, 0, 1, 32'h0, 0, 0, 1);
        add(1, 0, 0, 32'h0, 0, 0, 0);
        add(1, 1, 1, 32'h77, 1, 0, 1);
        add(1, 0, 1, 32'h0, 0, 0, 0);
        // Build to 3, then 10 simultaneous write+read cycles across pointer wrap
        for (int k = 0; k < 3; k++) add(1, 1, 0, 32'h100 + k, k + 1, 0, 0);
        for (int k = 0; k < 10; k++) add(1, 1, 1, 32'h200 + k, 3, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 1, 1, 32'h300 + k, 3, 0, 0);
        add(1, 1, 0, 32'h400, 4, 0, 0);
        add(1, 1, 0, 32'h401, 5, 0, 0);

        rst = 1'b1; cs = 1'b1; wr_ena = 1'b1; rd_ena = 1'b1; data_in = 32'h55;
        tick();
        chk_std("reset", 0, 0, 0, 32'h0);
        rst = 1'b0;
        exp_dout = 32'h0;
        mcnt = 0;

        for (int i = 0; i < vec.size(); i++) begin
            cs = vec[i].c; wr_ena = vec[i].w; rd_ena = vec[i].r; data_in = vec[i].d;
            wacc = vec[i].c && vec[i].w && (mcnt < 8);
            racc = vec[i].c && vec[i].r && (mcnt > 0);
            if (racc) exp_dout = sb.pop_front();
            if (wacc) sb.push_back(vec[i].d);
            tick();
            chk_std($sformatf("v%0d", i), vec[i].cnt, vec[i].ovf, vec[i].udf, exp_dout);
            mcnt = vec[i].cnt;
        end

        // Mid-run reset at count 5 with a same-edge write: everything discarded
        rst = 1'b1; cs = 1'b1; wr_ena = 1'b1; rd_ena = 1'b0; data_in = 32'h500;
        tick();
        chk_std("midrst", 0, 0, 0, 32'h0);
        sb.delete();
        rst = 1'b0; data_in = 32'hC3;
        tick();
        chk_std("midrst_wr", 1, 0, 0, 32'h0);
        wr_ena = 1'b0; rd_ena = 1'b1;
        tick();
        chk_std("midrst_rd", 0, 0, 0, 32'hC3);

        // FWFT instance
        rst = 1'b1; rd_ena = 1'b0;
        tick();
        rst = 1'b0;
        chk("fwft reset data_out", 64'(d1_data_out), 64'h0);
        chk("fwft reset empty", 64'(d1_empty), 64'h1);
        wr_ena = 1'b1; data_in = 32'hA5;
        #2;
        chk("fwft pre-edge data_out", 64'(d1_data_out), 64'h0);
        tick();
        wr_ena = 1'b0;
        chk("fwft write empty", 64'(d1_empty), 64'h0);
        chk("fwft write data_out", 64'(d1_data_out), 64'hA5);
        tick();
        chk("fwft hold data_out", 64'(d1_data_out), 64'hA5);
        rd_ena = 1'b1;
        tick();
        rd_ena = 1'b0;
        chk("fwft pop data_out", 64'(d1_data_out), 64'h0);
        chk("fwft pop empty", 64'(d1_empty), 64'h1);
        wr_ena = 1'b1; data_in = 32'hB1;
        tick();
        data_in = 32'hB2;
        tick();
        wr_ena = 1'b0;
        chk("fwft two count", 64'(d1_count), 64'h2);
        chk("fwft head B1", 64'(d1_data_out), 64'hB1);
        rd_ena = 1'b1;
        tick();
        chk("fwft head B2", 64'(d1_data_out), 64'hB2);
        tick();
        rd_ena = 1'b0;
        chk("fwft drained data_out", 64'(d1_data_out), 64'h0);
        chk("fwft drained empty", 64'(d1_empty), 64'h1);
        chk("fwft almost_empty", 64'(d1_ae), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
